// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: default stage indices, stage vector type and
// a saturating counter increment used by the spine's performance counters.
package cpu_pipe_pkg;
    localparam int NSTAGES_DEF = 4;
    localparam int STG_D = 0;
    localparam int STG_E = 1;
    localparam int STG_M = 2;
    localparam int STG_W = 3;

    typedef logic [NSTAGES_DEF-1:0] stage_vec_t;

    // Increment v, sticking at the all-ones value of a w-bit counter (w <= 64).
    function automatic logic [63:0] satInc(input logic [63:0] v, input int w);
        logic [63:0] maxv;
        maxv = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= maxv) ? v : v + 64'd1;
    endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// One valid+payload pipeline register: reset > flush > hold > bubble > load.
module pipe_stage_reg #(
    parameter int unsigned WIDTH       = 96,
    parameter bit          BUBBLE_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             hold,
    input  logic             bubble,
    input  logic             loadValid,
    input  logic [WIDTH-1:0] loadData,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush || (!hold && bubble)) begin
            // A flushed slot and an inserted bubble look identical downstream.
            valid <= 1'b0;
            if (BUBBLE_ZERO) data <= '0;
        end else if (!hold) begin
            valid <= loadValid;
            data  <= loadData;
        end
    end
endmodule

// File: rtl/pipe_spine.sv
// In-order pipeline register spine: backward stall propagation, bubble insertion,
// per-stage flush and saturating stall/bubble counters.
module pipe_spine
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned NSTAGES     = 4,
    parameter int unsigned WIDTH       = 96,
    parameter bit          BUBBLE_ZERO = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    input  logic [NSTAGES-1:0]       stall_req,
    input  logic [NSTAGES-1:0]       flush,
    output logic [NSTAGES-1:0]       stage_valid,
    output logic [NSTAGES*WIDTH-1:0] stage_data,
    output logic                     out_fire,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
);
    logic [NSTAGES-1:0]            hold;
    logic [NSTAGES-1:0]            bubble;
    logic [NSTAGES-1:0]            vld;
    logic [NSTAGES-1:0][WIDTH-1:0] dat;
    logic                          bubbleTaken;

    for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
        logic             loadValid;
        logic [WIDTH-1:0] loadData;

        if (i == NSTAGES - 1) begin : g_last
            assign hold[i] = stall_req[i];
        end else begin : g_mid
            assign hold[i] = stall_req[i] | hold[i+1];
        end

        if (i == STG_D) begin : g_head
            assign bubble[i]  = 1'b0;
            assign loadValid  = in_valid;
            assign loadData   = in_data;
        end else begin : g_body
            // Boundary where the older side runs and the younger side is frozen.
            assign bubble[i]  = hold[i-1] & ~hold[i];
            assign loadValid  = vld[i-1];
            assign loadData   = dat[i-1];
        end

        pipe_stage_reg #(
            .WIDTH       (WIDTH),
            .BUBBLE_ZERO (BUBBLE_ZERO)
        ) u_reg (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush[i]),
            .hold      (hold[i]),
            .bubble    (bubble[i]),
            .loadValid (loadValid),
            .loadData  (loadData),
            .valid     (vld[i]),
            .data      (dat[i])
        );
    end

    assign in_ready    = ~hold[0];
    assign stage_valid = vld;
    assign stage_data  = dat;
    assign out_fire    = vld[NSTAGES-1] & ~stall_req[NSTAGES-1];
    // A bubble overridden by a flush on the same stage is not counted.
    assign bubbleTaken = |(bubble & ~flush);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready)
                stall_cnt <= CNT_W'(satInc(64'(stall_cnt), CNT_W));
            if (bubbleTaken)
                bubble_cnt <= CNT_W'(satInc(64'(bubble_cnt), CNT_W));
        end
    end
endmodule

// File: tb/tb_pipe_spine.sv
// Directed bench for pipe_spine: three instances (default, payload-keeping
// bubbles, 4-bit counters) share one stimulus stream.
module tb_pipe_spine;
    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [95:0] inData;
    logic [3:0]  stallReq;
    logic [3:0]  flush;

    logic        aReady, aFire, bReady, bFire, cReady, cFire;
    logic [3:0]  aValid, bValid, cValid;
    logic [383:0] aData, bData, cData;
    logic [31:0] aStall, aBubble, bStall, bBubble;
    logic [3:0]  cStall, cBubble;

    int nChecks = 0;
    int nPass   = 0;

    always #5 clk = ~clk;

    pipe_spine u_a (
        .clk(clk), .reset(rst), .in_valid(inValid), .in_data(inData), .in_ready(aReady),
        .stall_req(stallReq), .flush(flush), .stage_valid(aValid), .stage_data(aData),
        .out_fire(aFire), .stall_cnt(aStall), .bubble_cnt(aBubble)
    );
    pipe_spine #(.BUBBLE_ZERO(1'b0)) u_b (
        .clk(clk), .reset(rst), .in_valid(inValid), .in_data(inData), .in_ready(bReady),
        .stall_req(stallReq), .flush(flush), .stage_valid(bValid), .stage_data(bData),
        .out_fire(bFire), .stall_cnt(bStall), .bubble_cnt(bBubble)
    );
    pipe_spine #(.CNT_W(4)) u_c (
        .clk(clk), .reset(rst), .in_valid(inValid), .in_data(inData), .in_ready(cReady),
        .stall_req(stallReq), .flush(flush), .stage_valid(cValid), .stage_data(cData),
        .out_fire(cFire), .stall_cnt(cStall), .bubble_cnt(cBubble)
    );

    function automatic logic [95:0] aD(input int i);
        return aData[i*96 +: 96];
    endfunction
    function automatic logic [95:0] bD(input int i);
        return bData[i*96 +: 96];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; inValid = 1'b0; inData = '0; stallReq = '0; flush = '0;
        tick(); tick();
        nChecks++;
        if (aValid !== 4'b0000 || aData !== '0) $display("FAIL reset_stages valid=%b data=%h exp valid=0 data=0", aValid, aData);
        else nPass++;
        nChecks++;
        if (aStall !== 32'd0 || aBubble !== 32'd0) $display("FAIL reset_counters stall=%0d bubble=%0d exp 0/0", aStall, aBubble);
        else nPass++;
        nChecks++;
        if (aReady !== 1'b1 || aFire !== 1'b0) $display("FAIL reset_comb ready=%b fire=%b exp 1/0", aReady, aFire);
        else nPass++;
    endtask

    task automatic test_stream();
        rst = 1'b0; inValid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            inData = 96'(k);
            tick();
            nChecks++;
            if (aValid[0] !== 1'b1 || aD(0) !== 96'(k)) $display("FAIL stream_s0 k=%0d got v=%b d=%h exp v=1 d=%h", k, aValid[0], aD(0), k);
            else nPass++;
            nChecks++;
            if (aValid[3] !== (k >= 4) || aFire !== (k >= 4) || (k >= 4 && aD(3) !== 96'(k - 3)))
                $display("FAIL stream_s3 k=%0d got v=%b fire=%b d=%h exp v=%0d d=%h", k, aValid[3], aFire, aD(3), k >= 4, k - 3);
            else nPass++;
        end
        nChecks++;
        if (aStall !== 32'd0 || aBubble !== 32'd0) $display("FAIL stream_counters stall=%0d bubble=%0d exp 0/0", aStall, aBubble);
        else nPass++;
    endtask

    // Spine holds 8,7,6,5 on entry.
    task automatic test_stall_mid();
        stallReq = 4'b0100; inData = 96'd9;
        #1;
        nChecks++;
        if (aReady !== 1'b0 || aFire !== 1'b1) $display("FAIL stall_comb ready=%b fire=%b exp 0/1", aReady, aFire);
        else nPass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            nChecks++;
            if (aValid !== 4'b0111 || aD(0) !== 96'd8 || aD(1) !== 96'd7 || aD(2) !== 96'd6 || aD(3) !== 96'd0)
                $display("FAIL stall_frozen c=%0d valid=%b d0=%h d1=%h d2=%h d3=%h exp 0111 8 7 6 0", c, aValid, aD(0), aD(1), aD(2), aD(3));
            else nPass++;
        end
        nChecks++;
        if (aStall !== 32'd3 || aBubble !== 32'd3) $display("FAIL stall_counters stall=%0d bubble=%0d exp 3/3", aStall, aBubble);
        else nPass++;
        stallReq = 4'b0000;
        tick();
        nChecks++;
        if (aValid !== 4'b1111 || aD(0) !== 96'd9 || aD(3) !== 96'd6)
            $display("FAIL stall_release valid=%b d0=%h d3=%h exp 1111 9 6", aValid, aD(0), aD(3));
        else nPass++;
    endtask

    // Spine holds 9,8,7,6 on entry.
    task automatic test_load_use();
        stallReq = 4'b0001; inData = 96'd10;
        tick();
        nChecks++;
        if (aValid !== 4'b1101 || aD(0) !== 96'd9 || aD(1) !== 96'd0 || aD(2) !== 96'd8 || aD(3) !== 96'd7)
            $display("FAIL loaduse_bubble valid=%b d0=%h d1=%h d2=%h d3=%h exp 1101 9 0 8 7", aValid, aD(0), aD(1), aD(2), aD(3));
        else nPass++;
        nChecks++;
        if (aBubble !== 32'd4 || aStall !== 32'd4) $display("FAIL loaduse_counters bubble=%0d stall=%0d exp 4/4", aBubble, aStall);
        else nPass++;
        stallReq = 4'b0000;
        tick();
        nChecks++;
        if (aValid !== 4'b1011 || aD(0) !== 96'd10 || aD(1) !== 96'd9 || aD(3) !== 96'd8)
            $display("FAIL loaduse_resume valid=%b d0=%h d1=%h d3=%h exp 1011 10 9 8", aValid, aD(0), aD(1), aD(3));
        else nPass++;
    endtask

    // Spine holds 10,9,hole,8 on entry.
    task automatic test_flush_stall();
        flush = 4'b0011; stallReq = 4'b0001; inData = 96'd11;
        tick();
        nChecks++;
        if (aValid !== 4'b0100 || aD(0) !== 96'd0 || aD(1) !== 96'd0 || aD(2) !== 96'd9 || aD(3) !== 96'd0)
            $display("FAIL flush_stall valid=%b d0=%h d1=%h d2=%h d3=%h exp 0100 0 0 9 0", aValid, aD(0), aD(1), aD(2), aD(3));
        else nPass++;
        flush = 4'b0000; stallReq = 4'b0000;
    endtask

    task automatic test_flush_keep();
        rst = 1'b1; tick();
        rst = 1'b0; inValid = 1'b1;
        inData = 96'h21; tick();
        inData = 96'h22; tick();
        flush = 4'b0010; inData = 96'h23;
        tick();
        flush = 4'b0000;
        nChecks++;
        if (bValid[2:0] !== 3'b101 || bD(1) !== 96'h21 || bD(0) !== 96'h23 || bD(2) !== 96'h21)
            $display("FAIL flush_keep valid=%b d0=%h d1=%h d2=%h exp x101 23 21 21", bValid, bD(0), bD(1), bD(2));
        else nPass++;
        nChecks++;
        if (aValid[1] !== 1'b0 || aD(1) !== 96'd0) $display("FAIL flush_zero v1=%b d1=%h exp 0 0", aValid[1], aD(1));
        else nPass++;
    endtask

    task automatic test_saturate();
        rst = 1'b1; tick();
        rst = 1'b0; inValid = 1'b1; inData = 96'h31; stallReq = 4'b0000;
        tick();
        stallReq = 4'b0001;
        for (int c = 0; c < 20; c++) tick();
        nChecks++;
        if (cStall !== 4'd15 || cBubble !== 4'd15) $display("FAIL sat_narrow stall=%0d bubble=%0d exp 15/15", cStall, cBubble);
        else nPass++;
        nChecks++;
        if (aStall !== 32'd20 || aBubble !== 32'd20) $display("FAIL sat_wide stall=%0d bubble=%0d exp 20/20", aStall, aBubble);
        else nPass++;
        nChecks++;
        if (cValid[0] !== 1'b1 || cData[95:0] !== 96'h31) $display("FAIL sat_held v0=%b d0=%h exp 1 31", cValid[0], cData[95:0]);
        else nPass++;
        rst = 1'b1; flush = 4'b1111;
        tick();
        nChecks++;
        if (cValid !== 4'b0000 || aValid !== 4'b0000 || cStall !== 4'd0 || cBubble !== 4'd0 || aStall !== 32'd0)
            $display("FAIL reset_mid_stall cvalid=%b avalid=%b cstall=%0d cbubble=%0d astall=%0d exp all 0", cValid, aValid, cStall, cBubble, aStall);
        else nPass++;
        rst = 1'b0; flush = 4'b0000; stallReq = 4'b0000; inValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_mid();
        test_load_use();
        test_flush_stall();
        test_flush_keep();
        test_saturate();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
